// File: rtl/pa_isa_pkg.sv
// ----------------------------------------------------------------------------
// pa_isa_pkg
//   Shared ISA definitions for the fetch->parse link: slot/bundle widths,
//   field bit positions inside a 30-bit slot, the decoded instruction record
//   and the slot decode helpers used by bundle_parse.
// ----------------------------------------------------------------------------
package pa_isa_pkg;

    localparam int SLOT_W   = 30;
    localparam int BUNDLE_W = 2 * SLOT_W;

    // Field positions inside one slot
    localparam int FMT_BIT = 29;
    localparam int BR_BIT  = 28;
    localparam int OPC_HI  = 27;
    localparam int OPC_LO  = 21;
    localparam int RA_HI   = 20;
    localparam int RA_LO   = 16;
    localparam int RB_HI   = 15;
    localparam int RB_LO   = 11;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;

    localparam logic [6:0] OPC_NOP = 7'd0;

    typedef struct packed {
        logic        format;   // 1 = reg-imm, 0 = reg-reg
        logic        branch;
        logic [6:0]  opcode;
        logic [4:0]  rega;
        logic [4:0]  regb;
        logic [15:0] imm;
    } decoded_inst_t;

    // Split a slot into fields; the operand field the format does not use is
    // forced to zero so downstream never sees stale bits.
    function automatic decoded_inst_t decode_slot(input logic [SLOT_W-1:0] s);
        decoded_inst_t d;
        d.format = s[FMT_BIT];
        d.branch = s[BR_BIT];
        d.opcode = s[OPC_HI:OPC_LO];
        d.rega   = s[RA_HI:RA_LO];
        if (s[FMT_BIT]) begin
            d.regb = '0;
            d.imm  = s[IMM_HI:IMM_LO];
        end else begin
            d.regb = s[RB_HI:RB_LO];
            d.imm  = '0;
        end
        return d;
    endfunction

    function automatic logic is_nop(input decoded_inst_t d);
        return (d.opcode == OPC_NOP) && !d.branch;
    endfunction

endpackage

// File: rtl/bundle_parse_if.sv
// ----------------------------------------------------------------------------
// bundle_parse_if
//   Signals between fetch, the bundle parser and the issue consumer.
//     data_i / enable_i / stall_o   : bundle input side (fetch -> parser)
//     inst_valid_o / inst_ready_i   : issue handshake (parser -> downstream)
//     inst_*_o                      : decoded head instruction fields
//   Modports: slave = parser view, master = environment view.
// ----------------------------------------------------------------------------
interface bundle_parse_if;

    logic [pa_isa_pkg::BUNDLE_W-1:0] data_i;
    logic                            enable_i;
    logic                            stall_o;
    logic                            inst_valid_o;
    logic                            inst_ready_i;
    logic                            inst_format_o;
    logic                            inst_branch_o;
    logic [6:0]                      inst_opcode_o;
    logic [4:0]                      inst_rega_o;
    logic [4:0]                      inst_regb_o;
    logic [15:0]                     inst_imm_o;

    modport slave (
        input  data_i, enable_i, inst_ready_i,
        output stall_o, inst_valid_o, inst_format_o, inst_branch_o,
               inst_opcode_o, inst_rega_o, inst_regb_o, inst_imm_o
    );

    modport master (
        output data_i, enable_i, inst_ready_i,
        input  stall_o, inst_valid_o, inst_format_o, inst_branch_o,
               inst_opcode_o, inst_rega_o, inst_regb_o, inst_imm_o
    );

endinterface

// File: rtl/bundle_parse_inst_queue.sv
// ----------------------------------------------------------------------------
// inst_queue
//   In-order FIFO of decoded instructions. Accepts 0, 1 or 2 entries per cycle
//   (push_a_i first, then push_b_i) and releases at most one per cycle.
//   The head entry is presented combinationally (first-word-fall-through).
//   Ports:
//     clock_i, reset_i (async, active-low), flush_i (empties queue)
//     push_cnt_i, push_a_i, push_b_i : entries to write this cycle
//     pop_i                          : remove head (caller guarantees count>0)
//     head_o, count_o                : head entry and occupancy
//   The caller guarantees at least push_cnt_i free entries when pushing.
// ----------------------------------------------------------------------------
module inst_queue
    import pa_isa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic [1:0]                   push_cnt_i,
    input  decoded_inst_t                push_a_i,
    input  decoded_inst_t                push_b_i,
    input  logic                         pop_i,
    output decoded_inst_t                head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    decoded_inst_t    r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    // Explicit wrap so depths that are not a power of two work too.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input int unsigned n);
        int unsigned s;
        s = 32'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    // NOTE: storage is reset as well so the head fields read as zero after
    // reset; this costs reset routing to every entry but is required here.
    // NOTE: all state uses non-blocking assignments so every read in this
    // block sees the pre-edge value, independent of statement order.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_mem    <= '{default: '0};
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_cnt_i != 2'd0) r_mem[r_wr_ptr] <= push_a_i;
            if (push_cnt_i == 2'd2) r_mem[ptr_add(r_wr_ptr, 1)] <= push_b_i;
            r_wr_ptr <= ptr_add(r_wr_ptr, 32'(push_cnt_i));
            if (pop_i) r_rd_ptr <= ptr_add(r_rd_ptr, 1);
            r_count  <= r_count + CNT_W'(push_cnt_i) - CNT_W'(pop_i);
        end
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

endmodule

// File: rtl/bundle_parse.sv
// ----------------------------------------------------------------------------
// bundle_parse
//   Consumer end of the fetch->parse link. Splits each 60-bit bundle into two
//   30-bit slots (slot0 = [59:30] issued first), decodes them, buffers them in
//   an in-order queue and issues one instruction per cycle on valid/ready.
//   Ports:
//     clock_i, reset_i (async, active-low)
//     flushBack_i : empties the queue; same-cycle bundle discarded, not counted
//     bus         : bundle_parse_if.slave (data/enable/stall, issue handshake
//                   and decoded head fields)
//     dropped_o   : saturating count of bundles refused while stalled
//   Build option: define NOP_SQUASH_EN to drop slots with opcode 0 and
//   branch 0 before they enter the queue.
// ----------------------------------------------------------------------------
module bundle_parse
    import pa_isa_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int DROP_CNT_W  = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  flushBack_i,
    bundle_parse_if.slave         bus,
    output logic [DROP_CNT_W-1:0] dropped_o
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    decoded_inst_t    w_dec0;
    decoded_inst_t    w_dec1;
    decoded_inst_t    w_push_a;
    decoded_inst_t    w_push_b;
    decoded_inst_t    w_head;
    logic [1:0]       w_push_cnt;
    logic [CNT_W-1:0] w_count;
    logic             w_keep0;
    logic             w_keep1;
    logic             w_stall;
    logic             w_accept;
    logic             w_drop;
    logic             w_valid;
    logic             w_pop;

    logic [DROP_CNT_W-1:0] r_dropped;

    assign w_dec0 = decode_slot(bus.data_i[BUNDLE_W-1:SLOT_W]);
    assign w_dec1 = decode_slot(bus.data_i[SLOT_W-1:0]);

`ifdef NOP_SQUASH_EN
    assign w_keep0 = !is_nop(w_dec0);
    assign w_keep1 = !is_nop(w_dec1);
`else
    assign w_keep0 = 1'b1;
    assign w_keep1 = 1'b1;
`endif

    // Stall looks only at the registered count; a pop in the same cycle is
    // not credited, so there is no combinational path from inst_ready_i.
    assign w_stall  = (QUEUE_DEPTH - int'(w_count)) < 2;
    assign w_accept = bus.enable_i && !w_stall && !flushBack_i;
    assign w_drop   = bus.enable_i &&  w_stall && !flushBack_i;
    assign w_valid  = (w_count != '0);
    assign w_pop    = w_valid && bus.inst_ready_i;

    // Compact the kept slots so the queue always writes contiguous entries.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_push_cnt = 2'd0;
        w_push_a   = w_dec0;
        w_push_b   = w_dec1;
        if (w_accept) begin
            unique case ({w_keep0, w_keep1})
                2'b11: w_push_cnt = 2'd2;
                2'b10: w_push_cnt = 2'd1;
                2'b01: begin
                    w_push_cnt = 2'd1;
                    w_push_a   = w_dec1;
                end
                default: w_push_cnt = 2'd0;
            endcase
        end
    end

    inst_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .flush_i    (flushBack_i),
        .push_cnt_i (w_push_cnt),
        .push_a_i   (w_push_a),
        .push_b_i   (w_push_b),
        .pop_i      (w_pop),
        .head_o     (w_head),
        .count_o    (w_count)
    );

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_dropped <= '0;
        end else if (w_drop && (r_dropped != {DROP_CNT_W{1'b1}})) begin
            r_dropped <= r_dropped + 1'b1;
        end
    end

    assign dropped_o         = r_dropped;
    assign bus.stall_o       = w_stall;
    assign bus.inst_valid_o  = w_valid;
    assign bus.inst_format_o = w_head.format;
    assign bus.inst_branch_o = w_head.branch;
    assign bus.inst_opcode_o = w_head.opcode;
    assign bus.inst_rega_o   = w_head.rega;
    assign bus.inst_regb_o   = w_head.regb;
    assign bus.inst_imm_o    = w_head.imm;

endmodule
